// File: rtl/si5338_loader_pkg.sv
// si5338_loader_pkg
// Shared constants and state encoding for the Si5338 register-map loader.
//   FRM_*      : fixed leading bytes of a single-register I2C write frame
//   DELAY_REG  : register field value that marks a ROM entry as a timed wait
//   FRM_BYTES  : number of command-memory bytes written per frame
//   loader_state_e : sequencer states
package si5338_loader_pkg;

    localparam logic [7:0] FRM_PRE_LEN     = 8'h02;
    localparam logic [7:0] FRM_RESTART     = 8'h00;
    localparam logic [7:0] FRM_PAYLOAD_LEN = 8'h01;
    localparam logic [7:0] DELAY_REG       = 8'hFF;

    localparam int unsigned FRM_BYTES = 6;

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StLatch,
        StMemstart,
        StWrite,
        StKick,
        StWaitDone,
        StDelay,
        StNext,
        StFinish
    } loader_state_e;

endpackage

// File: rtl/si5338_reg_loader.sv
// si5338_reg_loader
// Walks an external register ROM and programs the Si5338 through an I2C controller's
// command memory, one single-register write frame per ROM entry. Entries whose register
// field is DELAY_REG insert a wait of data x DELAY_UNIT_CYCLES clocks instead.
//
// Ports:
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   go_i               : start pulse (ignored unless idle)
//   busy_o             : sequence in progress
//   done_o             : one-cycle pulse after the last entry
//   error_o            : sticky I2C timeout flag, cleared by the next accepted go
//   progress_o         : index of the entry being processed
//   rom_addr_o         : ROM address; rom_data_i = {reg, data} valid one cycle later
//   i2c_memstart_o     : reset controller memory pointer (pulse)
//   i2c_memwrite_o     : write i2c_memdin_o and post-increment (pulse)
//   i2c_memdin_o       : command memory byte, valid with i2c_memwrite_o
//   i2c_start_o        : launch transfer (pulse)
//   i2c_done_i         : transfer complete (pulse)
module si5338_reg_loader
    import si5338_loader_pkg::*;
#(
    parameter int unsigned ADDR_W            = 9,
    parameter int unsigned NUM_ENTRIES       = 350,
    parameter logic [6:0]  DEV_ADDR          = 7'h70,
    parameter int unsigned DELAY_UNIT_CYCLES = 100800,
    parameter int unsigned TIMEOUT_CYCLES    = 2000000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              go_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic [ADDR_W-1:0] progress_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [15:0]       rom_data_i,
    output logic              i2c_memstart_o,
    output logic              i2c_memwrite_o,
    output logic [7:0]        i2c_memdin_o,
    output logic              i2c_start_o,
    input  logic              i2c_done_i
);

    // Wide enough for 255 delay units without overflow.
    localparam int unsigned DLY_W = $clog2(255 * DELAY_UNIT_CYCLES + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_ENTRIES - 1);
    localparam logic [2:0]        LAST_K   = 3'(FRM_BYTES - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    loader_state_e     state_q, state_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [2:0]        k_q, k_d;
    logic [7:0]        reg_q, reg_d;
    logic [7:0]        data_q, data_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [DLY_W-1:0]  dly_q, dly_d;
    logic              error_q, error_d;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              memstart_q, memstart_d;
    logic              memwrite_q, memwrite_d;
    logic [7:0]        memdin_q, memdin_d;
    logic              start_q, start_d;

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        k_d     = k_q;
        reg_d   = reg_q;
        data_d  = data_q;
        tmo_d   = tmo_q;
        dly_d   = dly_q;
        error_d = error_q;

        unique case (state_q)
            StIdle: begin
                if (go_i) begin
                    index_d = '0;
                    error_d = 1'b0;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                state_d = StLatch;
            end
            StLatch: begin
                reg_d  = rom_data_i[15:8];
                data_d = rom_data_i[7:0];
                if (rom_data_i[15:8] == DELAY_REG) begin
                    dly_d = DLY_W'(rom_data_i[7:0]) * DLY_W'(DELAY_UNIT_CYCLES);
                    // A zero-length delay skips the wait state entirely.
                    state_d = (rom_data_i[7:0] == 8'h00) ? StNext : StDelay;
                end else begin
                    state_d = StMemstart;
                end
            end
            StMemstart: begin
                k_d     = '0;
                state_d = StWrite;
            end
            StWrite: begin
                k_d = k_q + 3'd1;
                if (k_q == LAST_K) begin
                    state_d = StKick;
                end
            end
            StKick: begin
                // The start cycle counts as the first cycle of the wait window, so a
                // timeout raises error exactly TIMEOUT_CYCLES cycles after i2c_start.
                tmo_d   = TMO_W'(1);
                state_d = StWaitDone;
            end
            StWaitDone: begin
                // done has priority over a coincident terminal count.
                if (i2c_done_i) begin
                    state_d = StNext;
                end else if (tmo_q == TMO_LAST) begin
                    error_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            StDelay: begin
                if (dly_q == DLY_W'(1)) begin
                    state_d = StNext;
                end else begin
                    dly_d = dly_q - DLY_W'(1);
                end
            end
            StNext: begin
                if (index_q == LAST_IDX) begin
                    state_d = StFinish;
                end else begin
                    index_d = index_q + ADDR_W'(1);
                    state_d = StFetch;
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so each strobe is high
    // exactly during the cycle its state is active.
    always_comb begin
        busy_d     = (state_d != StIdle) && (state_d != StFinish);
        done_d     = (state_d == StFinish);
        memstart_d = (state_d == StMemstart);
        memwrite_d = (state_d == StWrite);
        start_d    = (state_d == StKick);
        memdin_d   = 8'h00;
        if (state_d == StWrite) begin
            unique case (k_d)
                3'd0:    memdin_d = FRM_PRE_LEN;
                3'd1:    memdin_d = FRM_RESTART;
                3'd2:    memdin_d = FRM_PAYLOAD_LEN;
                3'd3:    memdin_d = {DEV_ADDR, 1'b0};
                3'd4:    memdin_d = reg_d;
                3'd5:    memdin_d = data_d;
                default: memdin_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            index_q    <= '0;
            k_q        <= '0;
            reg_q      <= '0;
            data_q     <= '0;
            tmo_q      <= '0;
            dly_q      <= '0;
            error_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            memstart_q <= 1'b0;
            memwrite_q <= 1'b0;
            memdin_q   <= '0;
            start_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            k_q        <= k_d;
            reg_q      <= reg_d;
            data_q     <= data_d;
            tmo_q      <= tmo_d;
            dly_q      <= dly_d;
            error_q    <= error_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            memstart_q <= memstart_d;
            memwrite_q <= memwrite_d;
            memdin_q   <= memdin_d;
            start_q    <= start_d;
        end
    end

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign error_o        = error_q;
    assign progress_o     = index_q;
    assign rom_addr_o     = index_q;
    assign i2c_memstart_o = memstart_q;
    assign i2c_memwrite_o = memwrite_q;
    assign i2c_memdin_o   = memdin_q;
    assign i2c_start_o    = start_q;

endmodule

// File: tb/tb_si5338_reg_loader.sv
// tb_si5338_reg_loader
// Drives the loader against a behavioural ROM and I2C controller and compares entry
// timing, strobe counts, captured frames and completion/timeout behaviour with a model
// that sums per-entry durations straight from the timing rules.
module tb_si5338_reg_loader;

    localparam int unsigned ADDR_W = 3;
    localparam int unsigned N      = 8;
    localparam int unsigned U      = 10;
    localparam int unsigned TO     = 100;
    localparam logic [6:0]  DEV    = 7'h70;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              go_i;
    logic              busy_o;
    logic              done_o;
    logic              error_o;
    logic [ADDR_W-1:0] progress_o;
    logic [ADDR_W-1:0] rom_addr_o;
    logic [15:0]       rom_data_i;
    logic              i2c_memstart_o;
    logic              i2c_memwrite_o;
    logic [7:0]        i2c_memdin_o;
    logic              i2c_start_o;
    logic              i2c_done_i;

    si5338_reg_loader #(
        .ADDR_W           (ADDR_W),
        .NUM_ENTRIES      (N),
        .DEV_ADDR         (DEV),
        .DELAY_UNIT_CYCLES(U),
        .TIMEOUT_CYCLES   (TO)
    ) u_dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .go_i          (go_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .error_o       (error_o),
        .progress_o    (progress_o),
        .rom_addr_o    (rom_addr_o),
        .rom_data_i    (rom_data_i),
        .i2c_memstart_o(i2c_memstart_o),
        .i2c_memwrite_o(i2c_memwrite_o),
        .i2c_memdin_o  (i2c_memdin_o),
        .i2c_start_o   (i2c_start_o),
        .i2c_done_i    (i2c_done_i)
    );

    initial forever #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [15:0] rom_mem [N];
    int          lat_tab [N];   // controller latency per entry; 0 = never answers

    // Observations collected by the controller/monitor process.
    logic [7:0]  cmem [8];
    int          ptr = 0;
    int          done_cnt = 0;
    logic [47:0] frames [$];
    int          n_start, n_done, first_kind, done_cyc, err_cyc, busy_fall, rise_err;
    int          stb_cnt [N];
    int          fetch_cyc [N];
    int          overlap = 0;
    bit          spur = 1'b0;
    bit          busy_prev = 1'b0;
    bit          err_prev = 1'b0;
    logic [ADDR_W-1:0] prog_prev = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_neg();
        @(negedge clk_i);
        #1;
    endtask

    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    // Synchronous ROM: data follows the address by one cycle.
    initial begin
        logic [ADDR_W-1:0] a_q;
        a_q = '0;
        rom_data_i = '0;
        forever begin
            @(posedge clk_i);
            #1;
            rom_data_i = rom_mem[a_q];
            a_q = rom_addr_o;
        end
    end

    // Behavioural I2C controller plus output monitor, sampled mid-cycle.
    initial begin
        int nstb;
        i2c_done_i = 1'b0;
        forever begin
            @(negedge clk_i);
            i2c_done_i = 1'b0;
            if (!rst_ni) begin
                ptr = 0;
                done_cnt = 0;
            end else begin
                if (done_cnt > 0) begin
                    done_cnt--;
                    if (done_cnt == 0) i2c_done_i = 1'b1;
                end
                if (i2c_memstart_o) begin
                    ptr = 0;
                    if (first_kind == 0) first_kind = 1;
                end
                if (i2c_memwrite_o) begin
                    if (ptr < 8) cmem[ptr] = i2c_memdin_o;
                    ptr++;
                    if (first_kind == 0) first_kind = 2;
                end
                if (i2c_start_o) begin
                    frames.push_back({cmem[0], cmem[1], cmem[2], cmem[3], cmem[4], cmem[5]});
                    n_start++;
                    if (first_kind == 0) first_kind = 2;
                    if (lat_tab[progress_o] > 0) done_cnt = lat_tab[progress_o];
                end
                if (spur && i2c_memwrite_o && ptr == 3) begin
                    i2c_done_i = 1'b1;
                    spur = 1'b0;
                end
            end
            nstb = int'(i2c_memstart_o) + int'(i2c_memwrite_o) + int'(i2c_start_o) + int'(done_o);
            if (nstb > 1) overlap++;
            if (i2c_memstart_o || i2c_memwrite_o || i2c_start_o) stb_cnt[progress_o]++;
            if (busy_o && !busy_prev) begin
                fetch_cyc[0] = cyc;
                rise_err = int'(error_o);
            end
            if (busy_o && progress_o != prog_prev) fetch_cyc[progress_o] = cyc;
            if (done_o) begin
                n_done++;
                done_cyc = cyc;
            end
            if (error_o && !err_prev) err_cyc = cyc;
            if (!busy_o && busy_prev) busy_fall = cyc;
            busy_prev = busy_o;
            err_prev = error_o;
            prog_prev = progress_o;
        end
    end

    task automatic clear_obs();
        frames.delete();
        n_start = 0;
        n_done = 0;
        first_kind = 0;
        done_cyc = -1;
        err_cyc = -1;
        busy_fall = -1;
        rise_err = -1;
        for (int k = 0; k < N; k++) begin
            stb_cnt[k] = 0;
            fetch_cyc[k] = -1;
        end
    endtask

    task automatic rand_rom(input int lat_max);
        for (int k = 0; k < N; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                rom_mem[k] = {8'hFF, 8'($urandom_range(0, 4))};
            end else begin
                rom_mem[k] = {8'($urandom_range(0, 254)), 8'($urandom)};
            end
            lat_tab[k] = $urandom_range(1, lat_max);
        end
    endtask

    // One full sequence: model expected FETCH cycles, frames and the end event, run, compare.
    task automatic do_run(input string name, input bit dup_go, input bit spur_en);
        int          exp_fetch [N];
        logic [47:0] exp_frames [$];
        int          n_reach, t, g, exp_err, to_idx, limit;
        bit          to_hit;

        wait_neg();
        clear_obs();
        spur = spur_en;
        g = cyc;
        go_i = 1'b1;

        t = g + 1;
        to_hit = 1'b0;
        exp_err = 0;
        to_idx = 0;
        n_reach = N;
        for (int k = 0; k < N; k++) begin
            exp_fetch[k] = t;
            if (rom_mem[k][15:8] == 8'hFF) begin
                t += int'(rom_mem[k][7:0]) * int'(U) + 3;
            end else begin
                exp_frames.push_back({8'h02, 8'h00, 8'h01, DEV, 1'b0, rom_mem[k]});
                if (lat_tab[k] == 0) begin
                    to_hit = 1'b1;
                    exp_err = t + 9 + int'(TO);
                    to_idx = k;
                    n_reach = k + 1;
                    break;
                end
                t += 11 + lat_tab[k];
            end
        end

        wait_neg();
        go_i = 1'b0;
        limit = (to_hit ? exp_err : t) + 40;
        while (done_cyc < 0 && err_cyc < 0 && cyc < limit) begin
            wait_neg();
            if (dup_go) go_i = (cyc == g + 20);
        end
        go_i = 1'b0;
        repeat (3) wait_neg();

        check_eq({name, "_ended"}, (done_cyc >= 0 || err_cyc >= 0), 1);
        check_eq({name, "_err_at_go"}, rise_err, 0);
        check_eq({name, "_first_memstart"}, first_kind, 1);
        for (int k = 0; k < n_reach; k++) begin
            check_eq($sformatf("%s_fetch%0d", name, k), fetch_cyc[k], exp_fetch[k]);
            check_eq($sformatf("%s_strobes%0d", name, k), stb_cnt[k],
                     (rom_mem[k][15:8] == 8'hFF) ? 0 : 8);
        end
        check_eq({name, "_frame_count"}, frames.size(), exp_frames.size());
        for (int i = 0; i < exp_frames.size() && i < frames.size(); i++) begin
            check_eq($sformatf("%s_frame%0d", name, i), frames[i], exp_frames[i]);
        end
        check_eq({name, "_starts"}, n_start, exp_frames.size());
        if (to_hit) begin
            check_eq({name, "_err_cycle"}, err_cyc, exp_err);
            check_eq({name, "_busy_fall"}, busy_fall, exp_err);
            check_eq({name, "_no_done"}, n_done, 0);
            check_eq({name, "_progress"}, progress_o, to_idx);
            check_eq({name, "_error"}, error_o, 1);
        end else begin
            check_eq({name, "_done_cycle"}, done_cyc, t);
            check_eq({name, "_busy_fall"}, busy_fall, t);
            check_eq({name, "_done_once"}, n_done, 1);
            check_eq({name, "_progress"}, progress_o, N - 1);
            check_eq({name, "_error"}, error_o, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst_ni = 1'b0;
        go_i = 1'b0;
        for (int k = 0; k < N; k++) begin
            rom_mem[k] = '0;
            lat_tab[k] = 1;
        end
        clear_obs();

        repeat (3) wait_neg();
        check_eq("reset_outs", {busy_o, done_o, error_o, progress_o, rom_addr_o, i2c_memstart_o,
                                i2c_memwrite_o, i2c_memdin_o, i2c_start_o}, 0);
        rst_ni = 1'b1;
        repeat (2) wait_neg();
        check_eq("idle_busy", busy_o, 0);

        // Directed map: writes, a 3-unit delay, a zero delay, plus a repeated go and a
        // spurious i2c_done during WRITE that must both be ignored.
        rom_mem[0] = 16'hE610; rom_mem[1] = 16'h1B8A; rom_mem[2] = 16'hFF03;
        rom_mem[3] = 16'hE600; rom_mem[4] = 16'hFF00; rom_mem[5] = 16'h3155;
        rom_mem[6] = 16'hFF01; rom_mem[7] = 16'h5AA5;
        for (int k = 0; k < N; k++) lat_tab[k] = 50;
        do_run("directed", 1'b1, 1'b1);
        check_eq("spur_injected", spur, 0);

        // Controller never answers on entry 2.
        rand_rom(60);
        rom_mem[2] = {8'h45, 8'($urandom)};
        lat_tab[2] = 0;
        do_run("timeout", 1'b0, 1'b0);

        // Next go clears error.
        rand_rom(60);
        do_run("after_to", 1'b0, 1'b0);

        // done on the terminal timeout cycle wins.
        rand_rom(60);
        rom_mem[1] = {8'h21, 8'($urandom)};
        lat_tab[1] = int'(TO) - 1;
        do_run("coincide", 1'b0, 1'b0);

        for (int r = 0; r < 4; r++) begin
            rand_rom(60);
            do_run($sformatf("rand%0d", r), 1'b0, 1'b0);
        end

        // Reset while waiting for i2c_done.
        rand_rom(60);
        rom_mem[0] = {8'h10, 8'h01};
        lat_tab[0] = 30;
        wait_neg();
        clear_obs();
        go_i = 1'b1;
        wait_neg();
        go_i = 1'b0;
        for (int i = 0; i < 200 && n_start == 0; i++) wait_neg();
        check_eq("rst_pre_start", n_start, 1);
        repeat (5) wait_neg();
        check_eq("rst_pre_busy", busy_o, 1);
        #1 rst_ni = 1'b0;
        #1;
        check_eq("rst_async_outs", {busy_o, done_o, error_o, progress_o, rom_addr_o,
                                    i2c_memstart_o, i2c_memwrite_o, i2c_memdin_o,
                                    i2c_start_o}, 0);
        repeat (2) wait_neg();
        rst_ni = 1'b1;
        do_run("post_rst", 1'b0, 1'b0);

        check_eq("strobe_overlap", overlap, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
